// File: rtl/fb_pkg.sv
// Shared widths, default frame geometry and FSM state encoding for the framebuffer reader.
package fb_pkg;
  localparam int ADDR_W    = 16;
  localparam int PIX_W     = 2;
  localparam int FLAG_W    = 3;
  localparam int ENTRY_W   = PIX_W + FLAG_W;
  localparam int H_DEFAULT = 256;
  localparam int V_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/fb_skid_fifo.sv
// Two-entry FIFO holding pixel data plus sof/eol/eof; head is zero whenever empty.
module fb_skid_fifo
  import fb_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_data,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_head,
  output logic               o_valid,
  output logic [1:0]         o_count
);
  logic [ENTRY_W-1:0] r_mem [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic               w_pop;

  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;
  assign w_pop   = i_pop & o_valid;
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      // simultaneous push and pop leaves the occupancy unchanged
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/fb_reader.sv
// Raster-order framebuffer reader: issues 1-clk-latency reads and streams pixels with sideband flags.
//   state | meaning
//   IDLE  | waiting for start, no reads
//   RUN   | issuing reads while the FIFO has room
//   DRAIN | all reads issued, waiting for FIFO and in-flight read to empty
module fb_reader
  import fb_pkg::*;
#(
  parameter int unsigned       H_ACTIVE   = H_DEFAULT,
  parameter int unsigned       V_ACTIVE   = V_DEFAULT,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 16'h0000,
  parameter bit                CONTINUOUS = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ce,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof
);
  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(H_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(V_ACTIVE - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_x;
  logic [ADDR_W-1:0]   r_y;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_inflight;
  logic [FLAG_W-1:0]   r_if_flags;
  logic                w_issue;
  logic                w_room;
  logic                w_last;
  logic                w_pop;
  logic                w_fifo_valid;
  logic [1:0]          w_fifo_count;
  logic [ENTRY_W-1:0]  w_head;

  assign w_pop  = w_fifo_valid & pix_ready;
  assign w_last = (r_x == X_LAST) && (r_y == Y_LAST);
  // occupancy after this cycle's pop, including the read already in flight, must stay below 2
  assign w_room = ({1'b0, w_fifo_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    busy        = 1'b1;
    frame_done  = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        w_issue = w_room;
        if (w_issue && w_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((w_fifo_count == 2'd0) && !r_inflight) begin
          frame_done  = 1'b1;
          w_state_nxt = CONTINUOUS ? RUN : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_addr     <= BASE_ADDR;
      r_inflight <= 1'b0;
      r_if_flags <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_if_flags <= {(r_x == '0) && (r_y == '0), r_x == X_LAST, w_last};
        if (w_last) begin
          r_x    <= '0;
          r_y    <= '0;
          r_addr <= BASE_ADDR;
        end else begin
          r_addr <= r_addr + 1'b1;
          if (r_x == X_LAST) begin
            r_x <= '0;
            r_y <= r_y + 1'b1;
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
      end
    end
  end

  fb_skid_fifo u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (r_inflight),
    .i_data  ({rd_data, r_if_flags}),
    .i_pop   (pix_ready),
    .o_head  (w_head),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign rd_ce     = w_issue;
  assign rd_addr   = r_addr;
  assign pix_valid = w_fifo_valid;
  assign pix_data  = w_head[ENTRY_W-1:FLAG_W];
  assign pix_sof   = w_head[2];
  assign pix_eol   = w_head[1];
  assign pix_eof   = w_head[0];
endmodule

// File: tb/tb_fb_reader.sv
// Directed bench for fb_reader: three instances cover base frame, address wrap and continuous mode.
module tb_fb_reader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_ready = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;

  logic        busy0, fd_0, rd_ce0, pv0, sof0, eol0, eof0;
  logic [15:0] rd_addr0;
  logic [1:0]  rd_data0 = 2'b00, pd0;
  logic        busy1, fd_1, rd_ce1, pv1, sof1, eol1, eof1;
  logic [15:0] rd_addr1;
  logic [1:0]  rd_data1 = 2'b00, pd1;
  logic        busy2, fd_2, rd_ce2, pv2, sof2, eol2, eof2;
  logic [15:0] rd_addr2;
  logic [1:0]  rd_data2 = 2'b00, pd2;

  int vectors = 0;
  int miscompares = 0;
  int iss0 = 0, pop0 = 0, fd0 = 0;

  always #5 clk = ~clk;

  function automatic logic [1:0] ram_f(input logic [15:0] a);
    return a[1:0] ^ a[3:2];
  endfunction

  fb_reader #(.H_ACTIVE(4), .V_ACTIVE(2), .BASE_ADDR(16'h0000), .CONTINUOUS(1'b0)) u0 (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .frame_done(fd_0),
    .rd_addr(rd_addr0), .rd_ce(rd_ce0), .rd_data(rd_data0), .pix_data(pd0),
    .pix_valid(pv0), .pix_ready(pix_ready), .pix_sof(sof0), .pix_eol(eol0), .pix_eof(eof0));

  fb_reader #(.H_ACTIVE(4), .V_ACTIVE(1), .BASE_ADDR(16'hFFFE), .CONTINUOUS(1'b0)) u1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .frame_done(fd_1),
    .rd_addr(rd_addr1), .rd_ce(rd_ce1), .rd_data(rd_data1), .pix_data(pd1),
    .pix_valid(pv1), .pix_ready(pix_ready), .pix_sof(sof1), .pix_eol(eol1), .pix_eof(eof1));

  fb_reader #(.H_ACTIVE(4), .V_ACTIVE(2), .BASE_ADDR(16'h0000), .CONTINUOUS(1'b1)) u2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .frame_done(fd_2),
    .rd_addr(rd_addr2), .rd_ce(rd_ce2), .rd_data(rd_data2), .pix_data(pd2),
    .pix_valid(pv2), .pix_ready(pix_ready), .pix_sof(sof2), .pix_eol(eol2), .pix_eof(eof2));

  // framebuffer models: 1-clk registered read
  always @(posedge clk) begin
    if (rd_ce0) rd_data0 <= ram_f(rd_addr0);
    if (rd_ce1) rd_data1 <= ram_f(rd_addr1);
    if (rd_ce2) rd_data2 <= ram_f(rd_addr2);
  end

  always @(posedge clk) begin
    if (reset) begin
      iss0 <= 0;
      pop0 <= 0;
    end else begin
      if (rd_ce0) iss0 <= iss0 + 1;
      if (pv0 && pix_ready) pop0 <= pop0 + 1;
    end
    if (fd_0) fd0 <= fd0 + 1;
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({busy0, fd_0, rd_ce0, pv0, pd0, sof0, eol0, eof0} !== 9'b0)
      begin miscompares++; $display("FAIL reset_outs0 got %b want 0", {busy0, fd_0, rd_ce0, pv0, pd0, sof0, eol0, eof0}); end
    vectors++;
    if (rd_addr0 !== 16'h0000) begin miscompares++; $display("FAIL reset_addr0 got %h want 0000", rd_addr0); end
    vectors++;
    if (rd_addr1 !== 16'hFFFE) begin miscompares++; $display("FAIL reset_addr1 got %h want fffe", rd_addr1); end
    vectors++;
    if ({busy1, rd_ce1, pv1, busy2, rd_ce2, pv2} !== 6'b0)
      begin miscompares++; $display("FAIL reset_outs12 got %b want 0", {busy1, rd_ce1, pv1, busy2, rd_ce2, pv2}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_rate();
    int k;
    logic ev;
    pix_ready = 1'b1;
    start0 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      #1;
      ev = (c >= 3) && (c <= 10);
      k  = c - 3;
      vectors++;
      if (pv0 !== ev) begin miscompares++; $display("FAIL full_valid c=%0d got %b want %b", c, pv0, ev); end
      if (ev) begin
        vectors++;
        if ({pd0, sof0, eol0, eof0} !== {ram_f(16'(k)), k == 0, (k == 3) || (k == 7), k == 7})
          begin miscompares++; $display("FAIL full_pix k=%0d got %b want %b", k, {pd0, sof0, eol0, eof0},
                {ram_f(16'(k)), k == 0, (k == 3) || (k == 7), k == 7}); end
      end
      vectors++;
      if (fd_0 !== (c == 11)) begin miscompares++; $display("FAIL full_done c=%0d got %b", c, fd_0); end
      vectors++;
      if (busy0 !== (c <= 11)) begin miscompares++; $display("FAIL full_busy c=%0d got %b", c, busy0); end
      vectors++;
      if (rd_ce0 !== (c <= 8)) begin miscompares++; $display("FAIL full_rdce c=%0d got %b", c, rd_ce0); end
      if (c <= 8) begin
        vectors++;
        if (rd_addr0 !== 16'(c - 1)) begin miscompares++; $display("FAIL full_addr c=%0d got %h want %h", c, rd_addr0, 16'(c - 1)); end
      end
    end
  endtask

  task automatic test_stall();
    int k = 0;
    int d0 = fd0;
    logic holding = 1'b0;
    logic [4:0] held = '0;
    start0 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      pix_ready = (c % 2 == 1);
      #1;
      if (holding) begin
        vectors++;
        if ({pv0, pd0, sof0, eol0, eof0} !== {1'b1, held})
          begin miscompares++; $display("FAIL stall_hold c=%0d got %b want %b", c, {pv0, pd0, sof0, eol0, eof0}, {1'b1, held}); end
      end
      holding = pv0 && !pix_ready;
      held    = {pd0, sof0, eol0, eof0};
      if (pv0 && pix_ready) begin
        vectors++;
        if ({pd0, sof0, eol0, eof0} !== {ram_f(16'(k)), k == 0, (k == 3) || (k == 7), k == 7})
          begin miscompares++; $display("FAIL stall_pix k=%0d got %b", k, {pd0, sof0, eol0, eof0}); end
        k++;
      end
      vectors++;
      if (iss0 - pop0 > 2) begin miscompares++; $display("FAIL stall_outstanding c=%0d got %0d want <=2", c, iss0 - pop0); end
    end
    pix_ready = 1'b1;
    vectors++;
    if (k != 8) begin miscompares++; $display("FAIL stall_count got %0d want 8", k); end
    vectors++;
    if (fd0 - d0 != 1) begin miscompares++; $display("FAIL stall_done got %0d want 1", fd0 - d0); end
  endtask

  task automatic test_wrap();
    logic [15:0] wa [4];
    int n = 0;
    int k = 0;
    wa[0] = 16'hFFFE; wa[1] = 16'hFFFF; wa[2] = 16'h0000; wa[3] = 16'h0001;
    pix_ready = 1'b1;
    start1 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      #1;
      if (rd_ce1) begin
        vectors++;
        if (n >= 4) begin miscompares++; $display("FAIL wrap_extra_read addr %h", rd_addr1); end
        else if (rd_addr1 !== wa[n]) begin miscompares++; $display("FAIL wrap_addr n=%0d got %h want %h", n, rd_addr1, wa[n]); end
        n++;
      end
      if (pv1) begin
        vectors++;
        if (k >= 4) begin miscompares++; $display("FAIL wrap_extra_pixel got %b", pd1); end
        else if ({pd1, sof1, eol1, eof1} !== {ram_f(wa[k]), k == 0, k == 3, k == 3})
          begin miscompares++; $display("FAIL wrap_pix k=%0d got %b want %b", k, {pd1, sof1, eol1, eof1}, {ram_f(wa[k]), k == 0, k == 3, k == 3}); end
        k++;
      end
    end
    vectors++;
    if (n != 4 || k != 4) begin miscompares++; $display("FAIL wrap_counts reads %0d pixels %0d want 4 4", n, k); end
  endtask

  task automatic test_reset_mid();
    pix_ready = 1'b1;
    start0 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if ({busy0, fd_0, rd_ce0, pv0, pd0, sof0, eol0, eof0} !== 9'b0 || rd_addr0 !== 16'h0000)
      begin miscompares++; $display("FAIL midreset_outs got %b addr %h want 0", {busy0, fd_0, rd_ce0, pv0, pd0, sof0, eol0, eof0}, rd_addr0); end
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      #1;
      vectors++;
      if ({rd_ce0, pv0, busy0} !== 3'b0)
        begin miscompares++; $display("FAIL midreset_quiet c=%0d got %b want 000", c, {rd_ce0, pv0, busy0}); end
    end
    test_full_rate();
  endtask

  task automatic test_start_busy();
    int d0 = fd0;
    int np = 0;
    int nr = 0;
    pix_ready = 1'b1;
    start0 = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start0 = (c == 4) || (c == 11);
      #1;
      if (pv0) np++;
      if (rd_ce0) nr++;
    end
    start0 = 1'b0;
    vectors++;
    if (np != 8 || nr != 8) begin miscompares++; $display("FAIL busy_counts pixels %0d reads %0d want 8 8", np, nr); end
    vectors++;
    if (fd0 - d0 != 1) begin miscompares++; $display("FAIL busy_done got %0d want 1", fd0 - d0); end
    vectors++;
    if (busy0 !== 1'b0) begin miscompares++; $display("FAIL busy_idle got %b want 0", busy0); end
  endtask

  task automatic test_continuous();
    pix_ready = 1'b1;
    start2 = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      #1;
      vectors++;
      if (fd_2 !== ((c == 11) || (c == 22))) begin miscompares++; $display("FAIL cont_done c=%0d got %b", c, fd_2); end
      vectors++;
      if ((pv2 && sof2) !== ((c == 3) || (c == 14))) begin miscompares++; $display("FAIL cont_sof c=%0d got %b", c, pv2 && sof2); end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_start_busy();
    test_continuous();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fb_reader.md
FB_READER -- requirements
Module: fb_reader

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 256, pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 256, lines per frame; H_ACTIVE*V_ACTIVE SHALL NOT exceed 65536.
REQ-003 SHALL have parameter BASE_ADDR, default 16'h0000, framebuffer word address of pixel (0,0).
REQ-004 SHALL have parameter CONTINUOUS, default 0; 1 = restart the next frame automatically.
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle frame request.
REQ-008 SHALL have port busy, output, 1, high from frame acceptance until frame_done.
REQ-009 SHALL have port frame_done, output, 1, one-cycle pulse after the last pixel handshake.
REQ-010 SHALL have port rd_addr, output, 16, framebuffer read address.
REQ-011 SHALL have port rd_ce, output, 1, read enable; rd_addr is valid when it is high.
REQ-012 SHALL have port rd_data, input, 2, read data, valid exactly 1 clk after a cycle with rd_ce=1.
REQ-013 SHALL have ports pix_data (output, 2), pix_valid (output, 1) and pix_ready (input, 1), the pixel stream.
REQ-014 SHALL have ports pix_sof, pix_eol and pix_eof (outputs, 1 each), sideband flags qualified by pix_valid.

Function
REQ-015 SHALL implement states IDLE, RUN and DRAIN.
REQ-016 IDLE: rd_ce=0 and busy=0; start=1 SHALL go to RUN with x=0, y=0 and linear index 0.
REQ-017 RUN: rd_addr SHALL equal (BASE_ADDR + y*H_ACTIVE + x) mod 2^16, produced by an incrementing counter with no multiplier.
REQ-018 A read SHALL issue (rd_ce=1) only when fifo_count + inflight - pop < 2, where pop = pix_valid & pix_ready and inflight is 0 or 1.
REQ-019 On each issued read, x SHALL increment; at x=H_ACTIVE-1, x SHALL wrap to 0 and y SHALL increment.
REQ-020 Issuing pixel (H_ACTIVE-1, V_ACTIVE-1) SHALL move the state to DRAIN; DRAIN SHALL issue no reads.
REQ-021 rd_data SHALL be captured into a 2-entry FIFO 1 clk after issue, together with its flags.
REQ-022 Flags: sof is set for (0,0), eol for x=H_ACTIVE-1, and eof for the last pixel.
REQ-023 pix_valid SHALL equal FIFO not empty, and pix_data/flags SHALL be the FIFO head.
REQ-024 pix_data/flags SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-025 With pix_ready held high, sustained throughput SHALL be 1 pixel/clk, with first pix_valid 2 clk after start.
REQ-026 DRAIN: when the FIFO is empty and inflight=0, frame_done SHALL pulse for 1 clk, then the state goes to IDLE (CONTINUOUS=0) or RUN with counters cleared (CONTINUOUS=1).
REQ-027 start while busy=1 SHALL be ignored, never queued.
REQ-028 Address wrap 16'hFFFF->16'h0000 mid-frame (nonzero BASE_ADDR) SHALL be legal and continue seamlessly.
REQ-029 A write-capture and pop in the same cycle SHALL leave fifo_count unchanged with no data loss.

Reset
REQ-030 reset=1 SHALL force IDLE, x=y=0, inflight=0, FIFO empty, busy=0, frame_done=0, rd_ce=0, rd_addr=BASE_ADDR, pix_valid=0, pix_data=0 and all flags 0.
REQ-031 Reset mid-frame SHALL discard the frame; rd_data returning the next cycle SHALL be dropped.
REQ-032 After reset releases, no read SHALL issue until a new start.

Structure
REQ-033 Package fb_pkg SHALL hold ADDR_W=16, PIX_W=2, default H/V sizes and the state enum.
REQ-034 The 2-entry data+flags FIFO SHALL be sub-module fb_skid_fifo, and all other logic SHALL be in fb_reader.
REQ-035 The rd_addr/rd_ce/rd_data port SHALL connect directly to the 64K x 2 simple dual-port framebuffer read port (ceb=rd_ce, oce=1, 1-clk latency).

Verification
REQ-036 H=4, V=2, BASE=0, ready=1, start -> 8 pixels on consecutive clks matching RAM, sof on the 1st, eol on the 4th and 8th, eof on the 8th, frame_done 1 clk later.
REQ-037 Same frame with ready toggling 1010... -> no pixel lost or duplicated, data held while stalled, rd_ce never leaves more than 2 entries outstanding.
REQ-038 BASE=16'hFFFE, H=4, V=1 -> rd_addr sequence FFFE, FFFF, 0000, 0001.
REQ-039 Reset asserted 3 clks into a frame -> all outputs at reset values next clk; a later start yields a clean frame starting with sof.
REQ-040 start pulsed again while busy -> ignored, and exactly one frame_done occurs.
REQ-041 CONTINUOUS=1, two frames -> the second sof follows the first frame_done, and frame_done pulses once per frame.
